tof_frame_buffer: RTL and testbench
===================================

// Module: tof_frame_buffer
// PURPOSE
// - Upstream stage of the surface-read FSM: collects per-sensor 8x8 ToF zone frames from a valid/ready stream into a ping-pong RAM.
// - Raises drdy when every sensor has delivered a complete frame, then serves random reads at {sens,row,col}.
// - Write bank fills while the downstream FSM reads the other bank; banks swap only when the read side is released.
// PARAMETERS
// - N_SENS   8   sensors per set; the sensor field is 3 bits, so legal range is 1..8
// - DATA_W   16  distance sample width, bits
// PORTS
// - clk          in   1       system clock
// - rst          in   1       synchronous, active-high reset
// - s_valid      in   1       input sample valid
// - s_ready      out  1       input sample accepted when s_valid & s_ready
// - s_sens       in   3       sensor index of current sample
// - s_data       in   DATA_W  distance sample; zones arrive row-major, zone 0 first
// - s_last       in   1       marks zone 63 of a sensor frame
// - rd_addr      in   9       {sens[2:0],row[2:0],col[2:0]} read address into read bank
// - rd_data      out  DATA_W  read data, one cycle after rd_addr
// - rd_release   in   1       one-cycle pulse: downstream finished with read bank
// - drdy         out  1       read bank holds a complete set
// - frame_err    out  1       one-cycle pulse on malformed or illegal frame
// - drop_cnt     out  8       count of dropped frames, saturating at 255
// BEHAVIOUR
// - Clock and reset: single clock clk; reset is synchronous and active-high on rst.
// - Reset values: s_ready=0 during rst, drdy=0, frame_err=0, drop_cnt=0, rd_data=0, wr_bank=0, zone_cnt=0, sens_mask=0.
// - Write path:
//   - Each accepted sample writes addr {wr_bank, s_sens, zone_cnt[5:3], zone_cnt[2:0]} and increments zone_cnt (6 bits).
//   - The s_sens of the first beat of a frame is latched; the frame's sensor is that latched value.
// - Frame completion:
//   - s_last with zone_cnt==63: set sens_mask[sens] and clear zone_cnt.
//   - s_last with zone_cnt!=63, or zone_cnt==63 without s_last: pulse frame_err, increment drop_cnt, clear zone_cnt, leave the mask bit clear.
//   - A frame rejected this way still leaves its partial data in the bank; that data is overwritten later.
//   - s_sens >= N_SENS on the first beat: the frame is consumed but not written. Pulse frame_err at its s_last and increment drop_cnt.
//   - A repeat frame for a sensor whose mask bit is already set overwrites that sensor's data; the mask is unchanged.
// - FSM states:
//   - FILL: s_ready=1. When sens_mask becomes all-ones (low N_SENS bits), go to SWAP if drdy=0, otherwise to HOLD.
//   - HOLD: s_ready=0 until rd_release, then go to SWAP.
//   - SWAP: one cycle with s_ready=0. Toggle wr_bank, clear sens_mask, set drdy=1, go to FILL.
// - drdy:
//   - Rises the cycle after the SWAP cycle and stays high until rd_release.
//   - Falls the cycle after rd_release.
//   - rd_release while drdy=0 is ignored.
// - Simultaneous events: rd_release in the same cycle the mask completes means the read bank is free. Go straight to SWAP; drdy stays high through the swap.
// - Read path: rd_data <= ram[{~wr_bank, rd_addr}] every cycle, independent of drdy. Latency 1.
// - Reset mid-frame: the partial frame is discarded, the mask is cleared, and drdy drops. RAM contents are not cleared.
// - drop_cnt saturates at 8'hFF.
// STRUCTURE
// - Package tof_pkg:
//   - Constants: N_ZONES=64, ZONE_W=6, SENS_W=3, ADDR_W=9.
//   - Typedef for the fill FSM state enum {FILL, HOLD, SWAP}.
//   - Typedef tof_addr_t = struct {sens,row,col}.
// - Sub-module tof_dp_ram: 1024 x DATA_W simple dual-port RAM, one write port and one registered read port. Must infer block RAM.
// - Top level holds zone_cnt, sens_mask, bank pointer, FSM and error logic.
// TESTING
// - Single set: 8 sensors x 64 beats with data = {sens,zone}, then read all 512 addresses.
//   -> drdy=1 two cycles after the last beat; rd_data == {sens,row*8+col} one cycle after each address.
// - Back-pressure: send a second full set without rd_release.
//   -> s_ready=0 after the second mask completes; after a rd_release pulse, SWAP occurs and drdy stays 1; reads return the second set.
// - Short frame: s_last at zone 40 for sensor 3.
//   -> frame_err pulses once, drop_cnt=1, drdy stays 0 until a correct sensor-3 frame arrives.
// - Illegal sensor: N_SENS=4, frame with s_sens=5.
//   -> no write to the bank, frame_err at s_last, drop_cnt increments.
// - Same-cycle event: rd_release coincides with the final s_last of the next set.
//   -> SWAP next cycle, drdy never drops, bank toggled.
// - Mid-frame reset: assert rst at zone 30, then send a clean set.
//   -> drdy=0, drop_cnt=0 after reset; the clean set raises drdy normally.

Source files
------------

// File: rtl/tof_pkg.sv
// Shared constants and types for the ToF frame buffer: zone geometry,
// address layout and the fill-side FSM states.
package tof_pkg;

  localparam int N_ZONES = 64;
  localparam int ZONE_W  = 6;
  localparam int SENS_W  = 3;
  localparam int ADDR_W  = 9;

  typedef enum logic [1:0] {
    FILL,
    HOLD,
    SWAP
  } fill_state_t;

  typedef struct packed {
    logic [SENS_W-1:0] sens;
    logic [2:0]        row;
    logic [2:0]        col;
  } tof_addr_t;

endpackage

// File: rtl/tof_dp_ram.sv
// Simple dual-port RAM: one write port and one registered read port.
// The read register has a synchronous clear so it maps onto the block-RAM output register.
module tof_dp_ram #(
  parameter int DATA_W = 16,
  parameter int AW     = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_wr_en,
  input  logic [AW-1:0]     i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic [AW-1:0]     i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data
);

  logic [DATA_W-1:0] r_mem [0:(1<<AW)-1];
  logic [DATA_W-1:0] r_rd_data;

  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_data <= '0;
    end else begin
      r_rd_data <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/tof_frame_buffer.sv
// Collects per-sensor 8x8 zone frames into a ping-pong RAM; the read bank is
// handed to the downstream reader via drdy and swapped only after rd_release.
module tof_frame_buffer
  import tof_pkg::*;
#(
  parameter int N_SENS = 8,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [SENS_W-1:0] s_sens,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  input  logic              rd_release,
  output logic              drdy,
  output logic              frame_err,
  output logic [7:0]        drop_cnt
);

  fill_state_t       r_state;
  fill_state_t       w_state_next;
  logic              r_wr_bank;
  logic              r_drdy;
  logic              r_frame_err;
  logic [7:0]        r_drop_cnt;
  logic [ZONE_W-1:0] r_zone_cnt;
  logic [SENS_W-1:0] r_frame_sens;
  logic [N_SENS-1:0] r_sens_mask;
  logic [N_SENS-1:0] w_mask_next;
  logic              w_accept;
  logic              w_first;
  logic [SENS_W-1:0] w_sens;
  logic              w_illegal;
  logic              w_zone_end;
  logic              w_good_end;
  logic              w_bad_end;
  logic              w_mask_full;
  tof_addr_t         w_wr_addr;

  assign w_accept   = s_valid && s_ready;
  assign w_first    = (r_zone_cnt == '0);
  // The sensor of a frame is whatever its first beat carried.
  assign w_sens     = w_first ? s_sens : r_frame_sens;
  assign w_illegal  = (int'(w_sens) >= N_SENS);
  assign w_zone_end = (r_zone_cnt == ZONE_W'(N_ZONES - 1));
  assign w_good_end = w_accept && s_last && w_zone_end && !w_illegal;
  assign w_bad_end  = w_accept && ((s_last != w_zone_end) || (s_last && w_illegal));
  assign w_wr_addr  = '{sens: w_sens, row: r_zone_cnt[5:3], col: r_zone_cnt[2:0]};

  for (genvar gi = 0; gi < N_SENS; gi++) begin : g_mask
    assign w_mask_next[gi] = r_sens_mask[gi] || (w_good_end && (w_sens == SENS_W'(gi)));
  end
  assign w_mask_full = &w_mask_next;

  always_comb begin
    w_state_next = r_state;
    s_ready      = 1'b0;
    case (r_state)
      FILL: begin
        s_ready = !rst;
        // A release arriving with the final beat frees the read bank right away.
        if (w_mask_full) begin
          w_state_next = (!r_drdy || rd_release) ? SWAP : HOLD;
        end
      end
      HOLD:    if (rd_release) w_state_next = SWAP;
      SWAP:    w_state_next = FILL;
      default: w_state_next = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= FILL;
      r_wr_bank    <= 1'b0;
      r_drdy       <= 1'b0;
      r_frame_err  <= 1'b0;
      r_drop_cnt   <= '0;
      r_zone_cnt   <= '0;
      r_frame_sens <= '0;
      r_sens_mask  <= '0;
    end else begin
      r_state     <= w_state_next;
      r_frame_err <= w_bad_end;
      if (w_bad_end && (r_drop_cnt != 8'hFF)) begin
        r_drop_cnt <= r_drop_cnt + 8'd1;
      end
      if (w_accept) begin
        if (w_first) begin
          r_frame_sens <= s_sens;
        end
        r_zone_cnt <= (s_last || w_zone_end) ? '0 : r_zone_cnt + ZONE_W'(1);
      end
      if (r_state == SWAP) begin
        r_wr_bank   <= ~r_wr_bank;
        r_sens_mask <= '0;
        r_drdy      <= 1'b1;
      end else begin
        r_sens_mask <= w_mask_next;
        // drdy holds across a release that immediately hands over a new bank.
        if (rd_release && (w_state_next != SWAP)) begin
          r_drdy <= 1'b0;
        end
      end
    end
  end

  tof_dp_ram #(
    .DATA_W (DATA_W),
    .AW     (ADDR_W + 1)
  ) u_ram (
    .clk       (clk),
    .rst       (rst),
    .i_wr_en   (w_accept && !w_illegal),
    .i_wr_addr ({r_wr_bank, w_wr_addr}),
    .i_wr_data (s_data),
    .i_rd_addr ({~r_wr_bank, rd_addr}),
    .o_rd_data (rd_data)
  );

  assign drdy      = r_drdy;
  assign frame_err = r_frame_err;
  assign drop_cnt  = r_drop_cnt;

endmodule

// File: tb/tb_tof_frame_buffer.sv
// Directed bench for tof_frame_buffer: an 8-sensor instance for the main flows and a
// 4-sensor instance for illegal-sensor and drop-counter saturation cases.
module tb_tof_frame_buffer;

  logic        clk;
  logic        rst;
  logic        s_valid;
  logic        s_valid4;
  logic [2:0]  s_sens;
  logic [15:0] s_data;
  logic        s_last;
  logic [8:0]  rd_addr;
  logic        rd_release;
  logic        s_ready, s_ready4;
  logic [15:0] rd_data, rd_data4;
  logic        drdy, drdy4;
  logic        frame_err, frame_err4;
  logic [7:0]  drop_cnt, drop_cnt4;

  int n_vec   = 0;
  int n_miss  = 0;
  int err_cnt  = 0;
  int err4_cnt = 0;

  tof_frame_buffer #(.N_SENS(8), .DATA_W(16)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_sens     (s_sens),
    .s_data     (s_data),
    .s_last     (s_last),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rd_release (rd_release),
    .drdy       (drdy),
    .frame_err  (frame_err),
    .drop_cnt   (drop_cnt)
  );

  tof_frame_buffer #(.N_SENS(4), .DATA_W(16)) u_dut4 (
    .clk        (clk),
    .rst        (rst),
    .s_valid    (s_valid4),
    .s_ready    (s_ready4),
    .s_sens     (s_sens),
    .s_data     (s_data),
    .s_last     (s_last),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data4),
    .rd_release (1'b0),
    .drdy       (drdy4),
    .frame_err  (frame_err4),
    .drop_cnt   (drop_cnt4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_err)  err_cnt++;
    if (frame_err4) err4_cnt++;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  task automatic wait_ready(input bit to4);
    int n;
    n = 0;
    @(negedge clk);
    while (!(to4 ? s_ready4 : s_ready) && (n < 100)) begin
      n++;
      @(negedge clk);
    end
    if (n >= 100) check_val("ready_timeout", 32'(to4 ? s_ready4 : s_ready), 32'd1);
  endtask

  // Data of each beat is base | {sens, zone}; last_at < 0 means no s_last in the frame.
  task automatic send_frame(input int sens, input logic [15:0] base, input int nbeats,
                            input int last_at, input bit to4, input bit rel_last);
    for (int z = 0; z < nbeats; z++) begin
      s_sens     = 3'(sens);
      s_data     = base | 16'((sens << 6) | z);
      s_last     = (z == last_at);
      rd_release = rel_last && (z == nbeats - 1);
      if (to4) s_valid4 = 1'b1;
      else     s_valid  = 1'b1;
      wait_ready(to4);
      @(posedge clk); #1;
      s_valid    = 1'b0;
      s_valid4   = 1'b0;
      s_last     = 1'b0;
      rd_release = 1'b0;
    end
  endtask

  task automatic send_set(input logic [15:0] base, input int nsens, input bit to4);
    for (int s = 0; s < nsens; s++) send_frame(s, base, 64, 63, to4, 1'b0);
  endtask

  task automatic read_check(input string tag, input logic [15:0] base, input int step,
                            input int limit, input bit on4);
    for (int a = 0; a < limit; a += step) begin
      rd_addr = 9'(a);
      @(posedge clk); #1;
      check_val(tag, 32'(on4 ? rd_data4 : rd_data), 32'(base | 16'(a)));
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic pulse_release();
    rd_release = 1'b1;
    @(posedge clk); #1;
    rd_release = 1'b0;
  endtask

  initial begin
    rst = 1'b1; s_valid = 1'b0; s_valid4 = 1'b0; s_sens = '0; s_data = '0;
    s_last = 1'b0; rd_addr = '0; rd_release = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    // Reset state
    check_val("rst_s_ready",   32'(s_ready),   32'd0);
    check_val("rst_drdy",      32'(drdy),      32'd0);
    check_val("rst_frame_err", 32'(frame_err), 32'd0);
    check_val("rst_drop_cnt",  32'(drop_cnt),  32'd0);
    check_val("rst_rd_data",   32'(rd_data),   32'd0);
    rst = 1'b0;
    #1;
    check_val("fill_s_ready",  32'(s_ready),   32'd1);

    // Single complete set, full readback
    send_set(16'h0000, 8, 1'b0);
    check_val("set1_drdy_c1", 32'(drdy), 32'd0);
    tick();
    check_val("set1_drdy_c2", 32'(drdy), 32'd1);
    read_check("set1_read", 16'h0000, 1, 512, 1'b0);
    check_val("set1_err_cnt", 32'(err_cnt), 32'd0);

    // Back-pressure: second set with no release
    send_set(16'h1000, 8, 1'b0);
    check_val("bp_ready_low", 32'(s_ready), 32'd0);
    repeat (4) tick();
    check_val("bp_ready_hold", 32'(s_ready), 32'd0);
    check_val("bp_drdy_hold",  32'(drdy),    32'd1);
    read_check("bp_old_bank", 16'h0000, 64, 512, 1'b0);
    pulse_release();
    check_val("bp_swap_drdy",  32'(drdy),    32'd1);
    check_val("bp_swap_ready", 32'(s_ready), 32'd0);
    tick();
    check_val("bp_fill_drdy",  32'(drdy),    32'd1);
    check_val("bp_fill_ready", 32'(s_ready), 32'd1);
    read_check("bp_read", 16'h1000, 7, 512, 1'b0);
    pulse_release();
    check_val("rel_drdy_fall", 32'(drdy), 32'd0);
    pulse_release();
    check_val("rel_ignored_drdy",  32'(drdy),    32'd0);
    check_val("rel_ignored_ready", 32'(s_ready), 32'd1);

    // Malformed frames, a repeat frame, then completion by a good sensor-3 frame
    send_frame(3, 16'h2000, 41, 40, 1'b0, 1'b0);
    check_val("short_err_pulse", 32'(frame_err), 32'd1);
    check_val("short_drop_cnt",  32'(drop_cnt),  32'd1);
    tick();
    check_val("short_err_single", 32'(frame_err), 32'd0);
    check_val("short_err_cnt",    32'(err_cnt),   32'd1);
    send_frame(2, 16'h2000, 64, -1, 1'b0, 1'b0);
    tick();
    check_val("nolast_drop_cnt", 32'(drop_cnt), 32'd2);
    check_val("nolast_err_cnt",  32'(err_cnt),  32'd2);
    send_frame(0, 16'h7000, 64, 63, 1'b0, 1'b0);
    for (int s = 1; s < 8; s++) begin
      if (s != 3) send_frame(s, 16'h2000, 64, 63, 1'b0, 1'b0);
    end
    send_frame(0, 16'h2000, 64, 63, 1'b0, 1'b0);
    repeat (3) tick();
    check_val("no_s3_drdy",    32'(drdy),    32'd0);
    check_val("no_s3_ready",   32'(s_ready), 32'd1);
    check_val("repeat_err_cnt", 32'(err_cnt), 32'd2);
    send_frame(3, 16'h2000, 64, 63, 1'b0, 1'b0);
    check_val("s3_drdy_c1", 32'(drdy), 32'd0);
    tick();
    check_val("s3_drdy_c2", 32'(drdy), 32'd1);
    read_check("s3_read", 16'h2000, 5, 512, 1'b0);

    // Release coincides with the final beat of the next set
    send_set(16'h3000, 7, 1'b0);
    send_frame(7, 16'h3000, 64, 63, 1'b0, 1'b1);
    check_val("same_swap_drdy",  32'(drdy),    32'd1);
    check_val("same_swap_ready", 32'(s_ready), 32'd0);
    tick();
    check_val("same_fill_drdy",  32'(drdy),    32'd1);
    check_val("same_fill_ready", 32'(s_ready), 32'd1);
    read_check("same_read", 16'h3000, 9, 512, 1'b0);

    // Reset in the middle of a frame, then a clean set
    send_frame(0, 16'h5000, 30, -1, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    check_val("mid_rst_ready", 32'(s_ready), 32'd0);
    @(posedge clk); #1;
    check_val("mid_rst_drdy",     32'(drdy),     32'd0);
    check_val("mid_rst_drop_cnt", 32'(drop_cnt), 32'd0);
    check_val("mid_rst_rd_data",  32'(rd_data),  32'd0);
    rst = 1'b0;
    send_set(16'h4000, 8, 1'b0);
    check_val("clean_drdy_c1", 32'(drdy), 32'd0);
    tick();
    check_val("clean_drdy_c2", 32'(drdy), 32'd1);
    check_val("clean_err_cnt", 32'(err_cnt), 32'd2);
    read_check("clean_read", 16'h4000, 11, 512, 1'b0);

    // Illegal sensor on the 4-sensor instance
    send_frame(5, 16'hB000, 64, 63, 1'b1, 1'b0);
    check_val("ill_err_pulse", 32'(frame_err4), 32'd1);
    check_val("ill_drop_cnt",  32'(drop_cnt4),  32'd1);
    tick();
    check_val("ill_err_cnt", 32'(err4_cnt), 32'd1);
    check_val("ill_drdy",    32'(drdy4),    32'd0);
    send_set(16'h6000, 4, 1'b1);
    check_val("n4_drdy_c1", 32'(drdy4), 32'd0);
    tick();
    check_val("n4_drdy_c2", 32'(drdy4), 32'd1);
    read_check("n4_read", 16'h6000, 3, 256, 1'b1);
    for (int z = 0; z < 64; z += 21) begin
      rd_addr = 9'((5 << 6) | z);
      tick();
      check_val("ill_no_write", 32'(rd_data4 == (16'hB000 | 16'((5 << 6) | z))), 32'd0);
    end

    // Drop counter saturation with single-beat short frames
    for (int i = 0; i < 253; i++) send_frame(0, 16'h0000, 1, 0, 1'b1, 1'b0);
    check_val("drop_254", 32'(drop_cnt4), 32'd254);
    send_frame(0, 16'h0000, 1, 0, 1'b1, 1'b0);
    check_val("drop_255", 32'(drop_cnt4), 32'd255);
    for (int i = 0; i < 5; i++) send_frame(0, 16'h0000, 1, 0, 1'b1, 1'b0);
    check_val("drop_sat", 32'(drop_cnt4), 32'd255);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
